// File: rtl/divmod_pkg.sv
// Shared definitions for divmod_unit: FSM state encoding and step-counter sizing.
package divmod_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter must hold the value WIDTH itself, hence WIDTH+1 codes.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/divmod_ctrl.sv
// Sequencer for divmod_unit: IDLE/RUN/DONE state machine, step counter, busy and done.
module divmod_ctrl
  import divmod_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic b_zero,
  output logic accept,
  output logic run,
  output logic last_step,
  output logic busy,
  output logic done
);

  localparam int CW = cnt_width(WIDTH);

  state_t        state_reg, state_next;
  logic [CW-1:0] count_reg, count_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    accept     = 1'b0;
    last_step  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          count_next = CW'(WIDTH);
          state_next = b_zero ? DONE : RUN;
        end
      end
      RUN: begin
        count_next = count_reg - CW'(1);
        // The step taken on this edge is the last one; results land with it.
        if (count_reg == CW'(1)) begin
          last_step  = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign run  = (state_reg == RUN);
  assign done = (state_reg == DONE);
  assign busy = (state_reg == RUN) || (state_reg == DONE);

endmodule

// File: rtl/divmod_unit.sv
// Multi-cycle restoring divider, one quotient bit per clock. Define DIVMOD_SIGNED_EN
// to add the signed_op input for two's-complement division (truncating toward zero).
module divmod_unit
  import divmod_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
`ifdef DIVMOD_SIGNED_EN
  input  logic             signed_op,
`endif
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  // Assert asynchronously, release only after two clean clock edges.
  logic [1:0] rst_sync_reg;
  logic       rst_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync_reg <= 2'b00;
    else        rst_sync_reg <= {rst_sync_reg[0], 1'b1};
  end

  assign rst_n = rst_sync_reg[1];

  logic signed_mode;
`ifdef DIVMOD_SIGNED_EN
  assign signed_mode = signed_op;
`else
  assign signed_mode = 1'b0;
`endif

  logic             a_neg, b_neg, b_zero;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign a_neg  = signed_mode & A[WIDTH-1];
  assign b_neg  = signed_mode & B[WIDTH-1];
  assign a_mag  = a_neg ? -A : A;
  assign b_mag  = b_neg ? -B : B;
  assign b_zero = (B == '0);

  logic accept, run, last_step;

  divmod_ctrl #(.WIDTH(WIDTH)) u_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .b_zero    (b_zero),
    .accept    (accept),
    .run       (run),
    .last_step (last_step),
    .busy      (busy),
    .done      (done)
  );

  logic [WIDTH-1:0] dvd_reg, dvs_reg, prem_reg;
  logic [WIDTH-1:0] quotient_reg, remainder_reg;
  logic             q_neg_reg, r_neg_reg, div_zero_reg;

  logic [WIDTH:0]   shifted, trial;
  logic             fits;
  logic [WIDTH-1:0] q_step, r_step;

  // Divisor < 2^WIDTH, so a set top bit in the shifted remainder always fits;
  // otherwise the borrow out of the WIDTH+1 bit subtract decides.
  assign shifted = {prem_reg, dvd_reg[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs_reg};
  assign fits    = shifted[WIDTH] | ~trial[WIDTH];
  assign r_step  = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign q_step  = {dvd_reg[WIDTH-2:0], fits};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_reg       <= '0;
      dvs_reg       <= '0;
      prem_reg      <= '0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      q_neg_reg     <= 1'b0;
      r_neg_reg     <= 1'b0;
      div_zero_reg  <= 1'b0;
    end else if (accept) begin
      dvd_reg      <= a_mag;
      dvs_reg      <= b_mag;
      prem_reg     <= '0;
      q_neg_reg    <= a_neg ^ b_neg;
      r_neg_reg    <= a_neg;
      div_zero_reg <= b_zero;
      if (b_zero) begin
        quotient_reg  <= '1;
        remainder_reg <= A;
      end
    end else if (run) begin
      dvd_reg  <= q_step;
      prem_reg <= r_step;
      if (last_step) begin
        quotient_reg  <= q_neg_reg ? -q_step : q_step;
        remainder_reg <= r_neg_reg ? -r_step : r_step;
      end
    end
  end

  assign quotient  = quotient_reg;
  assign remainder = remainder_reg;
  assign div_zero  = div_zero_reg;

endmodule

// File: tb/tb_divmod_unit.sv
// Self-checking bench for divmod_unit: directed table, corner sequences and random ops.
module tb_divmod_unit;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        start32 = 1'b0, start8 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        sop = 1'b0;
  logic [31:0] q32, r32;
  logic [7:0]  q8, r8;
  logic        busy32, done32, dz32, busy8, done8, dz8;

  divmod_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .start(start32),
`ifdef DIVMOD_SIGNED_EN
    .signed_op(sop),
`endif
    .A(a32), .B(b32), .quotient(q32), .remainder(r32),
    .busy(busy32), .done(done32), .div_zero(dz32)
  );

  divmod_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8),
`ifdef DIVMOD_SIGNED_EN
    .signed_op(1'b0),
`endif
    .A(a8), .B(b8), .quotient(q8), .remainder(r8),
    .busy(busy8), .done(done8), .div_zero(dz8)
  );

  logic sel8 = 1'b0;
  wire [63:0] q_s    = sel8 ? {56'd0, q8} : {32'd0, q32};
  wire [63:0] r_s    = sel8 ? {56'd0, r8} : {32'd0, r32};
  wire        busy_s = sel8 ? busy8 : busy32;
  wire        done_s = sel8 ? done8 : done32;
  wire        dz_s   = sel8 ? dz8 : dz32;

  int total = 0;
  int passed = 0;
  logic [63:0] last_q, last_r, gq, gr, ta, tb;
  logic        gdz;
  int          glat, n, ndone, first_gap;

  typedef struct {
    logic [31:0] a, b, q, r;
    logic        dz;
    int          lat;
  } vec_t;
  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Reference: plain integer division from the operation's definition.
  function automatic void model(input bit w8, input logic [63:0] a_in, input logic [63:0] b_in,
                                input bit sgn, output logic [63:0] q, output logic [63:0] r,
                                output logic dz, output int lat);
    int w = w8 ? 8 : 32;
    logic [63:0] mask = (64'd1 << w) - 64'd1;
    logic [63:0] a = a_in & mask;
    logic [63:0] b = b_in & mask;
    longint sa, sb;
    dz  = (b == 0);
    lat = (b == 0) ? 1 : w + 1;
    if (b == 0) begin
      q = mask;
      r = a;
    end else if (sgn) begin
      sa = w8 ? longint'($signed(a[7:0])) : longint'($signed(a[31:0]));
      sb = w8 ? longint'($signed(b[7:0])) : longint'($signed(b[31:0]));
      q = 64'(sa / sb) & mask;
      r = 64'(sa % sb) & mask;
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  task automatic wait_idle();
    int g = 0;
    @(negedge clk);
    while (busy_s && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("idle_wait", 64'(busy_s), 64'd0);
  endtask

  // Issues one op, scrambles A/B after acceptance, returns results and cycles to done.
  task automatic run_op(input bit w8, input logic [63:0] a, input logic [63:0] b, input bit sgn,
                        output logic [63:0] q, output logic [63:0] r, output logic dz,
                        output int lat);
    sel8 = w8;
    wait_idle();
    sop = sgn;
    if (w8) begin a8 = a[7:0]; b8 = b[7:0]; start8 = 1'b1; end
    else begin a32 = a[31:0]; b32 = b[31:0]; start32 = 1'b1; end
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0; start32 = 1'b0;
    a32 = $urandom; b32 = $urandom; a8 = 8'($urandom); b8 = 8'($urandom);
    lat = 1;
    while (!done_s && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    q = q_s; r = r_s; dz = dz_s;
  endtask

  task automatic do_op(input bit w8, input logic [63:0] a, input logic [63:0] b, input bit sgn);
    logic [63:0] eq, er, oq, orr;
    logic edz, odz;
    int elat, olat;
    model(w8, a, b, sgn, eq, er, edz, elat);
    run_op(w8, a, b, sgn, oq, orr, odz, olat);
    $display("op w=%0d sgn=%0d a=%0h b=%0h -> q=%0h r=%0h dz=%0d lat=%0d (exp q=%0h r=%0h)",
             w8 ? 8 : 32, sgn, a, b, oq, orr, odz, olat, eq, er);
    check("latency", 64'(olat), 64'(elat));
    check("quotient", oq, eq);
    check("remainder", orr, er);
    check("div_zero", 64'(odz), 64'(edz));
    @(negedge clk);
    check("done_pulse", 64'(done_s), 64'd0);
    last_q = eq;
    last_r = er;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33};
    vecs[1] = '{32'd55, 32'd0, 32'hFFFFFFFF, 32'd55, 1'b1, 1};
    vecs[2] = '{32'd0, 32'd5, 32'd0, 32'd0, 1'b0, 33};
    vecs[3] = '{32'd3, 32'd10, 32'd0, 32'd3, 1'b0, 33};
    vecs[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 33};
    vecs[5] = '{32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0, 33};
    vecs[6] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFFE, 1'b0, 33};
    vecs[7] = '{32'hFFFFFFFF, 32'h80000000, 32'd1, 32'h7FFFFFFF, 1'b0, 33};
    vecs[8] = '{32'd305419896, 32'd1000, 32'd305419, 32'd896, 1'b0, 33};
    vecs[9] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'd0, 1'b1, 1};

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_q32", 64'(q32), 64'd0);
    check("rst_r32", 64'(r32), 64'd0);
    check("rst_busy32", 64'(busy32), 64'd0);
    check("rst_done32", 64'(done32), 64'd0);
    check("rst_dz32", 64'(dz32), 64'd0);
    check("rst_q8", 64'(q8), 64'd0);
    reset = 1'b1;
    repeat (4) @(negedge clk);

    // Directed table
    for (int i = 0; i < 10; i++) begin
      run_op(1'b0, 64'(vecs[i].a), 64'(vecs[i].b), 1'b0, gq, gr, gdz, glat);
      $display("vec %0d a=%0h b=%0h -> q=%0h r=%0h dz=%0d lat=%0d", i, vecs[i].a, vecs[i].b,
               gq, gr, gdz, glat);
      check($sformatf("vec%0d_q", i), gq, 64'(vecs[i].q));
      check($sformatf("vec%0d_r", i), gr, 64'(vecs[i].r));
      check($sformatf("vec%0d_dz", i), 64'(gdz), 64'(vecs[i].dz));
      check($sformatf("vec%0d_lat", i), 64'(glat), 64'(vecs[i].lat));
      @(negedge clk);
      check($sformatf("vec%0d_pulse", i), 64'(done_s), 64'd0);
    end

    // 8-bit instance: 255/16
    do_op(1'b1, 64'd255, 64'd16, 1'b0);
    check("w8_q", 64'(q8), 64'd15);
    check("w8_r", 64'(r8), 64'd15);

    // Start pulsed in the 5th RUN cycle must be ignored
    do_op(1'b0, 64'd50, 64'd9, 1'b0);
    sel8 = 1'b0;
    wait_idle();
    a32 = 32'd100; b32 = 32'd7; start32 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start32 = 1'b0;
    repeat (4) @(negedge clk);
    a32 = 32'd9; b32 = 32'd3; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0; a32 = '0; b32 = '0;
    check("hold_q", 64'(q32), last_q);
    check("hold_r", 64'(r32), last_r);
    n = 6;
    while (!done32 && n < 200) begin
      @(negedge clk);
      n++;
    end
    $display("busy-start seq: q=%0d r=%0d lat=%0d", q32, r32, n);
    check("busy_start_lat", 64'(n), 64'd33);
    check("busy_start_q", 64'(q32), 64'd14);
    check("busy_start_r", 64'(r32), 64'd2);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      if (done32) ndone++;
    end
    check("busy_start_no_2nd_done", 64'(ndone), 64'd0);

    // Start held high through DONE: next accept only from IDLE
    wait_idle();
    a32 = 32'd100; b32 = 32'd7; start32 = 1'b1;
    n = 0;
    while (!done32 && n < 200) begin
      @(negedge clk);
      n++;
    end
    first_gap = 0;
    do begin
      @(negedge clk);
      first_gap++;
    end while (!done32 && first_gap < 200);
    start32 = 1'b0;
    $display("held-start seq: gap=%0d q=%0d r=%0d", first_gap, q32, r32);
    check("held_start_gap", 64'(first_gap), 64'd34);
    check("held_start_q", 64'(q32), 64'd14);
    check("held_start_r", 64'(r32), 64'd2);

    // Reset in the 10th RUN cycle
    wait_idle();
    a32 = 32'd100; b32 = 32'd7; start32 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start32 = 1'b0;
    repeat (9) @(negedge clk);
    check("pre_reset_busy", 64'(busy32), 64'd1);
    check("pre_reset_q", 64'(q32), 64'd14);
    reset = 1'b0;
    #1;
    $display("mid-op reset: q=%0h r=%0h busy=%0d done=%0d dz=%0d", q32, r32, busy32, done32, dz32);
    check("reset_q", 64'(q32), 64'd0);
    check("reset_r", 64'(r32), 64'd0);
    check("reset_busy", 64'(busy32), 64'd0);
    check("reset_done", 64'(done32), 64'd0);
    check("reset_dz", 64'(dz32), 64'd0);
    ndone = 0;
    repeat (3) begin
      @(negedge clk);
      if (done32) ndone++;
    end
    reset = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (done32) ndone++;
    end
    check("reset_no_done", 64'(ndone), 64'd0);
    do_op(1'b0, 64'd20, 64'd6, 1'b0);
    check("reset_recover_q", 64'(q32), 64'd3);
    check("reset_recover_r", 64'(r32), 64'd2);

`ifdef DIVMOD_SIGNED_EN
    do_op(1'b0, 64'hFFFFFFF9, 64'd2, 1'b1);
    check("s_m7_2_q", 64'(q32), 64'hFFFFFFFD);
    check("s_m7_2_r", 64'(r32), 64'hFFFFFFFF);
    do_op(1'b0, 64'h80000000, 64'hFFFFFFFF, 1'b1);
    check("s_ovf_q", 64'(q32), 64'h80000000);
    check("s_ovf_r", 64'(r32), 64'd0);
    check("s_ovf_dz", 64'(dz32), 64'd0);
    do_op(1'b0, 64'hFFFFFFF9, 64'd0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      ta = 64'($urandom);
      case ($urandom_range(0, 3))
        0:       tb = 64'($urandom_range(1, 15));
        1:       tb = 64'(32'hFFFFFFFF - $urandom_range(0, 15));
        2:       tb = 64'($urandom);
        default: tb = (i % 5 == 0) ? 64'd0 : 64'($urandom);
      endcase
      do_op(1'b0, ta, tb, 1'b1);
    end
`endif

    // Random unsigned, both widths
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 7))
        0:       tb = 64'd0;
        1, 2:    tb = 64'($urandom_range(1, 15));
        default: tb = 64'($urandom);
      endcase
      ta = ($urandom_range(0, 3) == 0 && tb != 0) ? 64'($urandom) % tb : 64'($urandom);
      do_op(1'b0, ta, tb, 1'b0);
    end
    for (int i = 0; i < 15; i++) begin
      tb = ($urandom_range(0, 5) == 0) ? 64'd0 : 64'($urandom_range(1, 255));
      ta = 64'($urandom_range(0, 255));
      do_op(1'b1, ta, tb, 1'b0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
